// File: rtl/fir_mac_ctrl_if.sv
// ----------------------------------------------------------------------------
// fir_mac_ctrl_if
// Bundles every bus around the FIR MAC sequencer:
//   sample stream in   : s_valid, s_ready, s_data (Q1.15)
//   coefficient write  : coef_we, coef_addr, coef_data (Q1.15)
//   status             : busy
//   ALU initiator side : alu_a, alu_b, alu_en_mac, alu_clr_acc, alu_y, alu_sat
//   result stream out  : m_valid, m_ready, m_data (Q7.9), m_sat
// Modports:
//   master : the sequencer (fir_mac_ctrl)
//   slave  : its environment (sample source, coefficient loader, ALU, sink)
// ----------------------------------------------------------------------------
interface fir_mac_ctrl_if #(
    parameter int AW = 8
) ();
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;

    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef_data;

    logic          busy;

    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic          alu_en_mac;
    logic          alu_clr_acc;
    logic [15:0]   alu_y;
    logic          alu_sat;

    logic          m_valid;
    logic          m_ready;
    logic [15:0]   m_data;
    logic          m_sat;

    modport master (
        input  s_valid, s_data,
        input  coef_we, coef_addr, coef_data,
        input  alu_y, alu_sat,
        input  m_ready,
        output s_ready, busy,
        output alu_a, alu_b, alu_en_mac, alu_clr_acc,
        output m_valid, m_data, m_sat
    );

    modport slave (
        output s_valid, s_data,
        output coef_we, coef_addr, coef_data,
        output alu_y, alu_sat,
        output m_ready,
        input  s_ready, busy,
        input  alu_a, alu_b, alu_en_mac, alu_clr_acc,
        input  m_valid, m_data, m_sat
    );
endinterface

// File: rtl/fir_mac_ctrl.sv
// ----------------------------------------------------------------------------
// fir_mac_ctrl
// Sequencer for the FIR MAC ALU. Accepts one Q1.15 sample at a time into a
// circular delay line, clears the ALU accumulator, issues one MAC per tap
// (x[n-k] * h[k]), waits one settle cycle, then presents the ALU's Q7.9
// result on an output valid/ready stream. No arithmetic is done here.
//
// Ports:
//   clk      : clock
//   rst      : synchronous, active-high reset
//   tap_num  : [AW:0] active tap count, sampled on sample accept
//              (only with FIR_MAC_CTRL_TAPCNT_EN defined)
//   bus      : fir_mac_ctrl_if.master (sample in, coefficient write, busy,
//              ALU operands/controls/result, result out)
//
// Optional feature macro: FIR_MAC_CTRL_TAPCNT_EN
//   Defined   -> tap_num port exists; MAC runs clamp(tap_num, 1, NTAPS) cycles.
//   Undefined -> MAC always runs NTAPS cycles.
//
// Timing with m_ready high: accept in cycle 0, CLR in cycle 1, MAC in cycles
// 2..T+1, CAPT in T+2, m_valid high from cycle T+3 (T = active taps).
// ----------------------------------------------------------------------------
module fir_mac_ctrl #(
    parameter int NTAPS = 16,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FIR_MAC_CTRL_TAPCNT_EN
    input  logic [AW:0]     tap_num,
`endif
    fir_mac_ctrl_if.master  bus
);
    // Pointer/tap-index width; one extra bit is used for the wrap arithmetic.
    localparam int            PW       = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [PW:0]   NTAPS_W  = (PW+1)'(NTAPS);
    localparam logic [PW-1:0] LAST_TAP = PW'(NTAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_CAPT,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;      // slot holding the newest sample
    logic [PW-1:0] k_q, k_d;            // current tap index during MAC
    logic [PW-1:0] last_k_q, last_k_d;  // final tap index for this sample
    logic          m_valid_q, m_valid_d;
    logic [15:0]   m_data_q, m_data_d;
    logic          m_sat_q, m_sat_d;

    logic [15:0]   dline_q [NTAPS];
    logic [15:0]   coef_q  [NTAPS];

    logic          accept;
    logic          coef_wr;
    logic [PW-1:0] taps_last;
    logic [PW:0]   rd_sum;
    logic [PW-1:0] rd_idx;

    // Last tap index for the next sample, after clamping the requested count.
`ifdef FIR_MAC_CTRL_TAPCNT_EN
    always_comb begin
        if (tap_num == '0) begin
            taps_last = '0;
        end else if (int'(tap_num) > NTAPS) begin
            taps_last = LAST_TAP;
        end else begin
            taps_last = PW'(int'(tap_num) - 1);
        end
    end
`else
    assign taps_last = LAST_TAP;
`endif

    // x[n-k] lives at (wptr - k) mod NTAPS. Adding NTAPS before subtracting
    // keeps the sum non-negative, so a single conditional subtract wraps it
    // and NTAPS does not have to be a power of two.
    assign rd_sum = {1'b0, wptr_q} + NTAPS_W - {1'b0, k_q};
    assign rd_idx = (rd_sum >= NTAPS_W) ? PW'(rd_sum - NTAPS_W) : PW'(rd_sum);

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_sat   = m_sat_q;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        wptr_d          = wptr_q;
        k_d             = k_q;
        last_k_d        = last_k_q;
        m_valid_d       = m_valid_q;
        m_data_d        = m_data_q;
        m_sat_d         = m_sat_q;
        accept          = 1'b0;
        coef_wr         = 1'b0;
        bus.s_ready     = 1'b0;
        bus.busy        = 1'b1;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_en_mac  = 1'b0;
        bus.alu_clr_acc = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b0;
                // Out-of-range tap indices are dropped rather than aliased.
                coef_wr     = bus.coef_we && (int'(bus.coef_addr) < NTAPS);
                if (bus.s_valid) begin
                    accept   = 1'b1;
                    last_k_d = taps_last;
                    state_d  = S_CLR;
                end
            end
            S_CLR: begin
                bus.alu_clr_acc = 1'b1;
                k_d             = '0;
                state_d         = S_MAC;
            end
            S_MAC: begin
                bus.alu_en_mac = 1'b1;
                bus.alu_a      = dline_q[rd_idx];
                bus.alu_b      = coef_q[k_q];
                if (k_q == last_k_q) begin
                    state_d = S_CAPT;
                end else begin
                    k_d = PW'(k_q + 1'b1);
                end
            end
            S_CAPT: begin
                // The last MAC has landed in the accumulator; alu_y is final.
                m_data_d  = bus.alu_y;
                m_sat_d   = bus.alu_sat;
                m_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    wptr_d    = (wptr_q == LAST_TAP) ? '0 : PW'(wptr_q + 1'b1);
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            k_q       <= '0;
            last_k_q  <= LAST_TAP;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sat_q   <= 1'b0;
            // NOTE: the delay line and coefficient bank are cleared on reset
            // on purpose: an aborted computation must leave no stale history,
            // which costs a reset mux per storage bit.
            for (int i = 0; i < NTAPS; i++) begin
                dline_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            k_q       <= k_d;
            last_k_q  <= last_k_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sat_q   <= m_sat_d;
            if (accept) begin
                dline_q[wptr_q] <= bus.s_data;
            end
            if (coef_wr) begin
                coef_q[bus.coef_addr[PW-1:0]] <= bus.coef_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fir_mac_ctrl
// Two sequencer instances (NTAPS=4 and NTAPS=3) share one set of stimulus
// variables; `sel` routes strobes to one instance and selects which one is
// observed. Each instance drives its own behavioural ALU: signed 16x16
// product into a 40-bit accumulator, Q2.30 -> Q7.9 by round-half-up shift
// of 21 bits, saturating to 16 bits. force_sat ORs into the 4-tap ALU's
// saturation flag so m_sat capture and hold can be observed.
// Expected results are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_fir_mac_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_ctrl_if #(.AW(3)) b4 ();
    fir_mac_ctrl_if #(.AW(2)) b3 ();

    // Shared stimulus; sel = 0 targets the 4-tap instance, 1 the 3-tap one.
    logic        sel       = 1'b0;
    logic        s_valid   = 1'b0;
    logic [15:0] s_data    = '0;
    logic        coef_we   = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        m_ready   = 1'b1;
    logic        force_sat = 1'b0;
`ifdef FIR_MAC_CTRL_TAPCNT_EN
    logic [3:0]  tap_num4  = 4'd4;
    logic [2:0]  tap_num3  = 3'd3;
`endif

    assign b4.s_valid   = s_valid & ~sel;
    assign b3.s_valid   = s_valid & sel;
    assign b4.s_data    = s_data;
    assign b3.s_data    = s_data;
    assign b4.coef_we   = coef_we & ~sel;
    assign b3.coef_we   = coef_we & sel;
    assign b4.coef_addr = coef_addr[2:0];
    assign b3.coef_addr = coef_addr[1:0];
    assign b4.coef_data = coef_data;
    assign b3.coef_data = coef_data;
    assign b4.m_ready   = m_ready;
    assign b3.m_ready   = m_ready;

    fir_mac_ctrl #(.NTAPS(4), .AW(3)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
`ifdef FIR_MAC_CTRL_TAPCNT_EN
        .tap_num (tap_num4),
`endif
        .bus     (b4.master)
    );

    fir_mac_ctrl #(.NTAPS(3), .AW(2)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
`ifdef FIR_MAC_CTRL_TAPCNT_EN
        .tap_num (tap_num3),
`endif
        .bus     (b3.master)
    );

    // ---------------- behavioural ALUs ----------------
    function automatic logic [16:0] alu_out(input logic signed [39:0] acc);
        logic signed [39:0] r;
        r = (acc + 40'sd1048576) >>> 21;
        if (r > 40'sd32767)       return {1'b1, 16'h7FFF};
        else if (r < -40'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, r[15:0]};
    endfunction

    logic signed [39:0] acc4 = '0;
    logic signed [39:0] acc3 = '0;
    logic signed [31:0] p4, p3;
    logic [16:0]        o4, o3;

    assign p4 = $signed(b4.alu_a) * $signed(b4.alu_b);
    assign p3 = $signed(b3.alu_a) * $signed(b3.alu_b);

    always @(posedge clk) begin
        if (b4.alu_clr_acc)     acc4 <= '0;
        else if (b4.alu_en_mac) acc4 <= acc4 + 40'(p4);
        if (b3.alu_clr_acc)     acc3 <= '0;
        else if (b3.alu_en_mac) acc3 <= acc3 + 40'(p3);
    end

    assign o4         = alu_out(acc4);
    assign o3         = alu_out(acc3);
    assign b4.alu_y   = o4[15:0];
    assign b4.alu_sat = o4[16] | force_sat;
    assign b3.alu_y   = o3[15:0];
    assign b3.alu_sat = o3[16];

    // ---------------- observation mux ----------------
    logic        o_s_ready, o_busy, o_m_valid, o_m_sat, o_en, o_clr;
    logic [15:0] o_m_data, o_a, o_b;

    always_comb begin
        o_s_ready = sel ? b3.s_ready     : b4.s_ready;
        o_busy    = sel ? b3.busy        : b4.busy;
        o_m_valid = sel ? b3.m_valid     : b4.m_valid;
        o_m_data  = sel ? b3.m_data      : b4.m_data;
        o_m_sat   = sel ? b3.m_sat       : b4.m_sat;
        o_en      = sel ? b3.alu_en_mac  : b4.alu_en_mac;
        o_clr     = sel ? b3.alu_clr_acc : b4.alu_clr_acc;
        o_a       = sel ? b3.alu_a       : b4.alu_a;
        o_b       = sel ? b3.alu_b       : b4.alu_b;
    end

    // ALU control rules: en/clr exclusive, operands zero outside MAC.
    int viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if ((o_en && o_clr) || (!o_en && (o_a != 16'h0 || o_b != 16'h0))) viol++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        coef_we = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] addr, input logic [15:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic accept_sample(input logic [15:0] x);
        s_valid = 1'b1;
        s_data  = x;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // One complete transaction; hold > 0 applies that many cycles of
    // backpressure in OUT while attempting a coefficient overwrite.
    task automatic run_sample(input string tag, input logic [15:0] x,
                              input logic [15:0] exp_data, input logic exp_sat,
                              input int exp_taps, input int hold);
        int          lat;
        int          macs;
        int          clrs;
        int          bad;
        logic [15:0] cap_data;
        logic        cap_sat;
        check({tag, "_s_ready"}, 32'(o_s_ready), 32'd1);
        m_ready = (hold == 0);
        accept_sample(x);
        lat  = 1;
        macs = 0;
        clrs = 0;
        while (!o_m_valid && lat < 300) begin
            macs += int'(o_en);
            clrs += int'(o_clr);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_taps + 3));
        check({tag, "_mac_cycles"}, 32'(macs), 32'(exp_taps));
        check({tag, "_clr_cycles"}, 32'(clrs), 32'd1);
        check({tag, "_m_data"}, 32'(o_m_data), 32'(exp_data));
        check({tag, "_m_sat"}, 32'(o_m_sat), 32'(exp_sat));
        cap_data = o_m_data;
        cap_sat  = o_m_sat;
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                coef_we   = 1'b1;
                coef_addr = 4'd0;
                coef_data = 16'h0000;
                force_sat = 1'b0;
                @(negedge clk);
                if (!o_m_valid || o_m_data !== cap_data || o_m_sat !== cap_sat ||
                    o_s_ready || !o_busy) bad++;
            end
            coef_we = 1'b0;
            check({tag, "_hold_stable"}, 32'(bad), 32'd0);
            m_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, "_hs_m_valid"}, 32'(o_m_valid), 32'd0);
        check({tag, "_hs_s_ready"}, 32'(o_s_ready), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0] step_exp [5];
    logic [15:0] wrap_in  [7];
    logic [15:0] wrap_exp [7];

    initial begin
        step_exp = '{16'h0080, 16'h0100, 16'h0180, 16'h0200, 16'h0200};
        wrap_in  = '{16'h2000, 16'h4000, 16'h1000, 16'hE000, 16'h0800, 16'hC000, 16'h7FFF};
        wrap_exp = '{16'h0080, 16'h0100, 16'h0040, 16'hFF80, 16'h0020, 16'hFF00, 16'h0200};

        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_s_ready", 32'(o_s_ready), 32'd1);
        check("rst_busy",    32'(o_busy),    32'd0);
        check("rst_m_valid", 32'(o_m_valid), 32'd0);
        check("rst_m_data",  32'(o_m_data),  32'd0);
        check("rst_m_sat",   32'(o_m_sat),   32'd0);
        check("rst_en_mac",  32'(o_en),      32'd0);
        check("rst_clr_acc", 32'(o_clr),     32'd0);
        check("rst_alu_a",   32'(o_a),       32'd0);
        check("rst_alu_b",   32'(o_b),       32'd0);

        // Coefficients 0x4000; index 4 is out of range and must not alias h[0].
        for (int k = 0; k < 4; k++) write_coef(4'(k), 16'h4000);
        write_coef(4'd4, 16'h7FFF);

        // Impulse
        run_sample("imp0", 16'h7FFF, 16'h0100, 1'b0, 4, 0);
        run_sample("imp1", 16'h0000, 16'h0100, 1'b0, 4, 0);
        run_sample("imp2", 16'h0000, 16'h0100, 1'b0, 4, 0);
        run_sample("imp3", 16'h0000, 16'h0100, 1'b0, 4, 0);

        // Step
        for (int i = 0; i < 5; i++) begin
            run_sample($sformatf("step%0d", i), 16'h4000, step_exp[i], 1'b0, 4, 0);
        end

        // Backpressure with the saturation flag raised at capture
        force_sat = 1'b1;
        run_sample("bp", 16'h4000, 16'h0200, 1'b1, 4, 10);
        force_sat = 1'b0;
        // h[0] must have survived the writes attempted during backpressure
        run_sample("post_bp", 16'h4000, 16'h0200, 1'b0, 4, 0);

        // Reset in the middle of MAC (k = 2)
        accept_sample(16'h4000);
        repeat (3) @(negedge clk);
        check("pre_rst_en_mac", 32'(o_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_s_ready", 32'(o_s_ready), 32'd1);
        check("mid_rst_busy",    32'(o_busy),    32'd0);
        check("mid_rst_m_valid", 32'(o_m_valid), 32'd0);
        check("mid_rst_en_mac",  32'(o_en),      32'd0);
        for (int k = 0; k < 4; k++) write_coef(4'(k), 16'h4000);
        run_sample("rst_imp0", 16'h7FFF, 16'h0100, 1'b0, 4, 0);
        run_sample("rst_imp1", 16'h0000, 16'h0100, 1'b0, 4, 0);

        // Wrap on the 3-tap instance; index 3 is out of range
        sel = 1'b1;
        write_coef(4'd0, 16'h7FFF);
        write_coef(4'd1, 16'h0000);
        write_coef(4'd2, 16'h0000);
        write_coef(4'd3, 16'h4000);
        for (int i = 0; i < 7; i++) begin
            run_sample($sformatf("wrap%0d", i), wrap_in[i], wrap_exp[i], 1'b0, 3, 0);
        end
        sel = 1'b0;

`ifdef FIR_MAC_CTRL_TAPCNT_EN
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(4'(k), 16'h4000);
        tap_num4 = 4'd2;
        run_sample("tn2_0", 16'h4000, 16'h0080, 1'b0, 2, 0);
        run_sample("tn2_1", 16'h4000, 16'h0100, 1'b0, 2, 0);
        run_sample("tn2_2", 16'h4000, 16'h0100, 1'b0, 2, 0);
        tap_num4 = 4'd0;
        run_sample("tn0",   16'h4000, 16'h0080, 1'b0, 1, 0);
        tap_num4 = 4'd9;
        run_sample("tn9",   16'h4000, 16'h0200, 1'b0, 4, 0);
`endif

        check("alu_ctrl_rules", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_mac_ctrl.md
Name: fir_mac_ctrl

Overview:
Sequencer that drives the FIR MAC ALU (signed 16x16 multiplier plus wide accumulator, Q7.9 rounded and saturated result). It is the initiator side of the ALU's en_mac/clr_acc interface.
- Accepts Q1.15 samples on a valid/ready stream and holds them in a circular delay line.
- Holds a loadable coefficient bank.
- Per sample, clears the accumulator, issues one MAC per tap, then captures the ALU's Q7.9 result onto an output valid/ready stream.

Parameters:
NTAPS, 16, number of taps (delay-line depth and coefficient count); range 2..256.
AW, 8, coefficient address width; must satisfy 2^AW >= NTAPS.

Ports:
clk  in  1  clock.
rst  in  1  reset: one clock; reset is synchronous and active-high.
s_valid  in  1  input sample valid.
s_ready  out  1  high only in IDLE.
s_data  in  16  input sample, Q1.15 signed.
coef_we  in  1  coefficient write strobe.
coef_addr  in  AW  tap index k; writes with k >= NTAPS are ignored.
coef_data  in  16  coefficient, Q1.15 signed.
busy  out  1  high whenever state != IDLE.
alu_a  out  16  ALU operand a (delayed sample x[n-k]).
alu_b  out  16  ALU operand b (coefficient h[k]).
alu_en_mac  out  1  ALU MAC enable.
alu_clr_acc  out  1  ALU accumulator clear.
alu_y  in  16  ALU Q7.9 result, combinational from the accumulator.
alu_sat  in  1  ALU saturation flag.
m_valid  out  1  output result valid.
m_ready  in  1  downstream ready.
m_data  out  16  result, Q7.9.
m_sat  out  1  saturation flag registered with m_data.

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset values:
  - state=IDLE, wptr=0.
  - All delay-line entries and all coefficients = 0.
  - m_valid=0, m_data=0, m_sat=0.
  - alu_en_mac=0, alu_clr_acc=0, alu_a=0, alu_b=0.
  - s_ready=1, busy=0.
- FSM states: IDLE -> CLR -> MAC -> CAPT -> OUT -> IDLE.
- IDLE:
  - s_ready=1.
  - On s_valid: write buf[wptr] <= s_data and go to CLR.
  - coef_we writes coef[coef_addr] only in IDLE.
  - If coef_we and s_valid are both high in the same cycle, both take effect. The new coefficient is used for this sample.
- CLR: one cycle with alu_clr_acc=1, then go to MAC with k=0.
- MAC: NTAPS cycles, k = 0..NTAPS-1.
  - alu_en_mac=1.
  - alu_a = buf[(wptr-k) mod NTAPS], alu_b = coef[k]. Wrap-around is explicit, so NTAPS need not be a power of 2.
  - After k=NTAPS-1, go to CAPT.
- CAPT: one cycle with alu_en_mac=0, letting the accumulator settle. Then m_data <= alu_y, m_sat <= alu_sat, m_valid <= 1, go to OUT.
- OUT:
  - Hold m_valid, m_data and m_sat stable until m_valid && m_ready.
  - On handshake: m_valid <= 0, wptr <= (wptr+1) mod NTAPS, go to IDLE.
  - m_ready is ignored outside OUT.
- alu_a and alu_b are 0 outside MAC. alu_en_mac and alu_clr_acc are never high together.
- Latency: sample accepted in cycle 0 gives m_valid high in cycle NTAPS+3. Throughput is one sample per NTAPS+4 cycles with m_ready tied high.
- coef_we outside IDLE is ignored (busy is high).
- rst asserted mid-MAC or mid-OUT:
  - Aborts the computation and returns to IDLE next cycle.
  - The in-flight result is discarded; m_valid=0.
  - The delay line is zeroed and wptr=0.
- Arithmetic is done entirely by the ALU. This block does no rounding and no width changes.

Optional Feature:
FIR_MAC_CTRL_TAPCNT_EN
- With the macro: adds input port tap_num [AW:0], the number of active taps.
  - Sampled in IDLE on sample accept.
  - 0 is clamped to 1; values > NTAPS are clamped to NTAPS.
  - MAC runs for tap_num cycles (k = 0..tap_num-1), so latency is tap_num+3.
  - The delay line still advances by one entry per sample.
- Without the macro: the port does not exist and MAC always runs NTAPS cycles.

Test Plan:
- Impulse, NTAPS=4, all coefs 0x4000: feed 0x7FFF then three 0x0000 -> m_data = 0x0100 four times; m_sat=0; each m_valid rises 7 cycles after its accept.
- Step, NTAPS=4, coefs 0x4000: feed 0x4000 x5 -> m_data 0x0080, 0x0100, 0x0180, 0x0200, 0x0200. Also verify alu_en_mac is high exactly 4 cycles per sample and alu_clr_acc exactly 1 cycle.
- Backpressure: hold m_ready=0 for 10 cycles in OUT -> m_valid, m_data and m_sat stay stable; s_ready=0 and coef_we is ignored throughout. Release -> handshake, then s_ready=1 next cycle.
- Wrap, NTAPS=3, coefs {0x7FFF, 0, 0}: feed 7 distinct samples -> each output equals the current sample scaled (e.g. 0x2000 -> 0x0080); confirms wptr wraps 2 -> 0.
- Reset mid-MAC: assert rst at k=2 -> next cycle IDLE, m_valid=0, alu_en_mac=0. The following impulse 0x7FFF with coef[0]=0x4000 gives 0x0100 and no stale history.
- With FIR_MAC_CTRL_TAPCNT_EN, NTAPS=4, tap_num=2, step 0x4000 x3 -> 0x0080, 0x0100, 0x0100. Also tap_num=0 gives 1 MAC cycle.
